// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86 constants, register codes, write-back FSM state
//               type and a register one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  localparam int DATA_W = 64;
  localparam int NREG   = 15;

  // Register codes
  localparam logic [3:0] RRSP  = 4'd4;
  localparam logic [3:0] RNONE = 4'd15;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2
  } wb_state_t;

  // One-hot decode of a register code; RNONE (and anything >= NREG) maps to 0.
  function automatic logic [NREG-1:0] reg_onehot(input logic [3:0] r);
    logic [NREG-1:0] m;
    m = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r == 4'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : Pending-write mask for decode hazard detection. Bits are set
//               when a write is accepted and cleared once it has been driven
//               on the register-file port; a same-edge set overrides clear.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREG-1:0] set_i,
  input  logic [NREG-1:0] clr_i,
  output logic [NREG-1:0] pend_o
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Clear first, then set, so a register re-issued on its retiring edge stays pending
  always_comb begin
    pend_d = (pend_q & ~clr_i) | set_i;
  end

  // Mask register
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/regfile_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_sched
// Description : Serialises E/M write-back bundles onto a single register-file
//               write port (E first, then M) and exports a pending-write mask.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_sched
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pend_mask
);

  wb_state_t         state_q, state_d;

  // Only the M half of a bundle is needed after acceptance: the E write (if
  // any) is loaded straight into the output registers on the accept edge.
  logic [3:0]        dstm_q, dstm_d;
  logic [DATA_W-1:0] valm_q, valm_d;
  logic              needm_q, needm_d;

  logic              we_q, we_d;
  logic [3:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              need_e_in;
  logic              need_m_in;
  logic              accept;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;

  // Bundle normalisation, handshake and scoreboard set/clear vectors
  always_comb begin
    // A same-register collision drops E so the M (memory) value wins.
    need_e_in = (dstE != RNONE) && (dstE != dstM);
    need_m_in = (dstM != RNONE);
    // Stall only while the second write of a two-write bundle is still owed.
    wb_ready  = !((state_q == WR_E) && needm_q);
    accept    = wb_valid && wb_ready;
    set_mask  = '0;
    if (accept) begin
      if (need_e_in) set_mask = set_mask | reg_onehot(dstE);
      if (need_m_in) set_mask = set_mask | reg_onehot(dstM);
    end
    // The write currently on the port retires at the coming edge.
    clr_mask  = we_q ? reg_onehot(waddr_q) : '0;
  end

  // Next state plus the registered port values that belong to that state
  always_comb begin
    state_d = IDLE;
    we_d    = 1'b0;
    waddr_d = RNONE;
    wdata_d = '0;
    dstm_d  = dstm_q;
    valm_d  = valm_q;
    needm_d = needm_q;
    if ((state_q == WR_E) && needm_q) begin
      state_d = WR_M;
      we_d    = 1'b1;
      waddr_d = dstm_q;
      wdata_d = valm_q;
    end else if (accept) begin
      dstm_d  = dstM;
      valm_d  = valM;
      needm_d = need_m_in;
      if (need_e_in) begin
        state_d = WR_E;
        we_d    = 1'b1;
        waddr_d = dstE;
        wdata_d = valE;
      end else if (need_m_in) begin
        state_d = WR_M;
        we_d    = 1'b1;
        waddr_d = dstM;
        wdata_d = valM;
      end
    end
  end

  // State, holding and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dstm_q  <= RNONE;
      valm_q  <= '0;
      needm_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= RNONE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      dstm_q  <= dstm_d;
      valm_q  <= valm_d;
      needm_q <= needm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_i  (set_mask),
    .clr_i  (clr_mask),
    .pend_o (pend_mask)
  );

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_sched
// Description : Self-checking bench for regfile_write_sched: directed vector
//               table, reset-mid-popq sequence, and randomized traffic
//               against a queue-based write-back model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_sched;
  import y86_pkg::*;

  logic              clk;
  logic              rst;
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        dstE;
  logic [DATA_W-1:0] valE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valM;
  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [NREG-1:0]   pend_mask;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_sched dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .dstE      (dstE),
    .valE      (valE),
    .dstM      (dstM),
    .valM      (valM),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of writes accepted but not yet retired.
  // The head is the write on the port this cycle.
  typedef struct {
    logic [3:0]        addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t mq[$];

  function automatic logic [NREG-1:0] model_pend();
    logic [NREG-1:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].addr] = 1'b1;
    return m;
  endfunction

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_edge();
    bit acc;
    if (rst) begin
      mq.delete();
    end else begin
      acc = wb_valid && (mq.size() <= 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        if (dstE != 4'd15 && dstE != dstM) mq.push_back('{dstE, valE});
        if (dstM != 4'd15) mq.push_back('{dstM, valM});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_we"},    64'(rf_we),     64'(mq.size() > 0));
    chk({tag, "_ready"}, 64'(wb_ready),  64'(mq.size() <= 1));
    chk({tag, "_pend"},  64'(pend_mask), 64'(model_pend()));
    if (mq.size() > 0) begin
      chk({tag, "_addr"}, 64'(rf_waddr), 64'(mq[0].addr));
      chk({tag, "_data"}, 64'(rf_wdata), 64'(mq[0].data));
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    wb_valid = v;
    dstE     = de;
    valE     = ve;
    dstM     = dm;
    valM     = vm;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic        we;
    logic [3:0]  a;
    logic [63:0] d;
    logic        rdy;
    logic [14:0] pend;
  } vec_t;

  vec_t vecs[14];

  initial begin
    //           v   dstE   valE      dstM   valM       we  addr  data      rdy  pend
    vecs[0]  = '{0, 4'd15, 64'h0,    4'd15, 64'h0,     0, 4'd0, 64'h0,    1, 15'h0000};
    vecs[1]  = '{1, 4'd3,  64'h10,   4'd15, 64'h0,     1, 4'd3, 64'h10,   1, 15'h0008};
    vecs[2]  = '{1, 4'd5,  64'h22,   4'd15, 64'h0,     1, 4'd5, 64'h22,   1, 15'h0020};
    vecs[3]  = '{0, 4'd15, 64'h0,    4'd15, 64'h0,     0, 4'd0, 64'h0,    1, 15'h0000};
    vecs[4]  = '{1, 4'd4,  64'h1F8,  4'd0,  64'hABCD,  1, 4'd4, 64'h1F8,  0, 15'h0011};
    vecs[5]  = '{1, 4'd4,  64'h1F8,  4'd0,  64'hABCD,  1, 4'd0, 64'hABCD, 1, 15'h0001};
    vecs[6]  = '{0, 4'd15, 64'h0,    4'd15, 64'h0,     0, 4'd0, 64'h0,    1, 15'h0000};
    vecs[7]  = '{1, 4'd4,  64'h99,   4'd4,  64'h55,    1, 4'd4, 64'h55,   1, 15'h0010};
    vecs[8]  = '{1, 4'd15, 64'h77,   4'd15, 64'h88,    0, 4'd0, 64'h0,    1, 15'h0000};
    vecs[9]  = '{0, 4'd15, 64'h0,    4'd15, 64'h0,     0, 4'd0, 64'h0,    1, 15'h0000};
    vecs[10] = '{1, 4'd2,  64'h7,    4'd6,  64'h8,     1, 4'd2, 64'h7,    0, 15'h0044};
    vecs[11] = '{1, 4'd2,  64'h7,    4'd6,  64'h8,     1, 4'd6, 64'h8,    1, 15'h0040};
    vecs[12] = '{1, 4'd6,  64'h33,   4'd15, 64'h0,     1, 4'd6, 64'h33,   1, 15'h0040};
    vecs[13] = '{0, 4'd15, 64'h0,    4'd15, 64'h0,     0, 4'd0, 64'h0,    1, 15'h0000};

    // Reset for two cycles
    rst = 1'b1;
    drive(0, 4'd15, 64'h0, 4'd15, 64'h0);
    tick();
    tick();
    chk("rst_we",    64'(rf_we),     64'h0);
    chk("rst_pend",  64'(pend_mask), 64'h0);
    chk("rst_ready", 64'(wb_ready),  64'h1);
    chk("rst_addr",  64'(rf_waddr),  64'hF);
    chk("rst_data",  64'(rf_wdata),  64'h0);
    rst = 1'b0;
    tick();
    chk("idle_we",   64'(rf_we),     64'h0);
    chk("idle_pend", 64'(pend_mask), 64'h0);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].de, vecs[i].ve, vecs[i].dm, vecs[i].vm);
      tick();
      chk($sformatf("vec%0d_we", i),    64'(rf_we),     64'(vecs[i].we));
      chk($sformatf("vec%0d_ready", i), 64'(wb_ready),  64'(vecs[i].rdy));
      chk($sformatf("vec%0d_pend", i),  64'(pend_mask), 64'(vecs[i].pend));
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_addr", i), 64'(rf_waddr), 64'(vecs[i].a));
        chk($sformatf("vec%0d_data", i), 64'(rf_wdata), vecs[i].d);
      end
    end

    // Reset while the E half of a popq is on the port: M write must vanish
    drive(1, 4'd4, 64'h1F8, 4'd0, 64'hABCD);
    tick();
    chk("mrst_we_e",  64'(rf_we),    64'h1);
    chk("mrst_rdy_e", 64'(wb_ready), 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 4'd15, 64'h0, 4'd15, 64'h0);
    chk("mrst_we",   64'(rf_we),     64'h0);
    chk("mrst_pend", 64'(pend_mask), 64'h0);
    chk("mrst_rdy",  64'(wb_ready),  64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mrst_quiet%0d", i), 64'(rf_we), 64'h0);
    end

    // Randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      // Upstream holds a stalled bundle stable; otherwise present a new one.
      if (!(mq.size() == 2 && wb_valid)) begin
        logic [3:0] de, dm;
        de = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
        dm = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
        if ($urandom_range(0, 7) == 0) dm = de;
        drive($urandom_range(0, 3) != 0, de, {$urandom, $urandom}, dm, {$urandom, $urandom});
      end
      tick();
      chk_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
